// File: rtl/chr_ascii_render_pkg.sv
// Shared constants and FSM state type for the 8x8 ASCII glyph renderer.
package chr_ascii_render_pkg;

  localparam int unsigned CHR_W = 8;
  localparam int unsigned CHR_H = 8;
  localparam logic [7:0] CHR_FIRST = 8'h20;
  localparam logic [7:0] CHR_LAST  = 8'h7E;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/chr_ascii_render_font_rom.sv
// Combinational 8x8 font for printable ASCII; bit 63 is the top-left pixel.
// Output polarity: 0 = ink, 1 = background; unknown codes render as space.
module chr_font_rom
  import chr_ascii_render_pkg::*;
(
  input  logic [7:0]  index,
  output logic [63:0] glyph
);

  logic [63:0] ink;

  // Table is drawn with 1 = ink and inverted once at the output.
  always_comb begin
    ink = '0;
    case (index)
      8'h21: ink = 64'h00_10_10_10_10_00_10_00;  8'h22: ink = 64'h00_28_28_00_00_00_00_00;
      8'h23: ink = 64'h00_28_7C_28_7C_28_00_00;  8'h24: ink = 64'h00_3C_50_38_14_78_10_00;
      8'h25: ink = 64'h00_64_68_10_2C_4C_00_00;  8'h26: ink = 64'h00_30_48_30_54_48_34_00;
      8'h27: ink = 64'h00_10_10_00_00_00_00_00;  8'h28: ink = 64'h00_08_10_10_10_10_08_00;
      8'h29: ink = 64'h00_20_10_10_10_10_20_00;  8'h2A: ink = 64'h00_00_54_38_54_00_00_00;
      8'h2B: ink = 64'h00_10_10_7C_10_10_00_00;  8'h2C: ink = 64'h00_00_00_00_00_10_10_20;
      8'h2D: ink = 64'h00_00_00_7C_00_00_00_00;  8'h2E: ink = 64'h00_00_00_00_00_00_10_00;
      8'h2F: ink = 64'h00_04_08_10_20_40_00_00;  8'h30: ink = 64'h00_38_4C_54_64_44_38_00;
      8'h31: ink = 64'h00_10_30_10_10_10_38_00;  8'h32: ink = 64'h00_38_44_08_10_20_7C_00;
      8'h33: ink = 64'h00_78_04_38_04_04_78_00;  8'h34: ink = 64'h00_08_18_28_7C_08_08_00;
      8'h35: ink = 64'h00_7C_40_78_04_04_78_00;  8'h36: ink = 64'h00_38_40_78_44_44_38_00;
      8'h37: ink = 64'h00_7C_04_08_10_20_20_00;  8'h38: ink = 64'h00_38_44_38_44_44_38_00;
      8'h39: ink = 64'h00_38_44_44_3C_04_38_00;  8'h3A: ink = 64'h00_00_10_00_00_10_00_00;
      8'h3B: ink = 64'h00_00_10_00_00_10_10_20;  8'h3C: ink = 64'h00_08_10_20_10_08_00_00;
      8'h3D: ink = 64'h00_00_7C_00_7C_00_00_00;  8'h3E: ink = 64'h00_20_10_08_10_20_00_00;
      8'h3F: ink = 64'h00_38_44_08_10_00_10_00;  8'h40: ink = 64'h00_38_44_5C_58_40_38_00;
      8'h41: ink = 64'h00_18_24_42_7E_42_42_00;  8'h42: ink = 64'h00_78_44_78_44_44_78_00;
      8'h43: ink = 64'h00_38_44_40_40_44_38_00;  8'h44: ink = 64'h00_78_44_44_44_44_78_00;
      8'h45: ink = 64'h00_7C_40_78_40_40_7C_00;  8'h46: ink = 64'h00_7C_40_78_40_40_40_00;
      8'h47: ink = 64'h00_38_40_4C_44_44_3C_00;  8'h48: ink = 64'h00_44_44_7C_44_44_44_00;
      8'h49: ink = 64'h00_38_10_10_10_10_38_00;  8'h4A: ink = 64'h00_1C_08_08_08_48_30_00;
      8'h4B: ink = 64'h00_44_48_70_48_44_44_00;  8'h4C: ink = 64'h00_40_40_40_40_40_7C_00;
      8'h4D: ink = 64'h00_44_6C_54_44_44_44_00;  8'h4E: ink = 64'h00_44_64_54_4C_44_44_00;
      8'h4F: ink = 64'h00_38_44_44_44_44_38_00;  8'h50: ink = 64'h00_78_44_44_78_40_40_00;
      8'h51: ink = 64'h00_38_44_44_54_48_34_00;  8'h52: ink = 64'h00_78_44_44_78_48_44_00;
      8'h53: ink = 64'h00_3C_40_38_04_04_78_00;  8'h54: ink = 64'h00_7C_10_10_10_10_10_00;
      8'h55: ink = 64'h00_44_44_44_44_44_38_00;  8'h56: ink = 64'h00_44_44_44_44_28_10_00;
      8'h57: ink = 64'h00_44_44_44_54_6C_44_00;  8'h58: ink = 64'h00_44_28_10_10_28_44_00;
      8'h59: ink = 64'h00_44_44_28_10_10_10_00;  8'h5A: ink = 64'h00_7C_08_10_20_40_7C_00;
      8'h5B: ink = 64'h00_38_20_20_20_20_38_00;  8'h5C: ink = 64'h00_40_20_10_08_04_00_00;
      8'h5D: ink = 64'h00_38_08_08_08_08_38_00;  8'h5E: ink = 64'h00_10_28_44_00_00_00_00;
      8'h5F: ink = 64'h00_00_00_00_00_00_00_7C;  8'h60: ink = 64'h00_20_10_00_00_00_00_00;
      8'h61: ink = 64'h00_00_38_04_3C_44_3C_00;  8'h62: ink = 64'h00_40_40_78_44_44_78_00;
      8'h63: ink = 64'h00_00_38_40_40_40_38_00;  8'h64: ink = 64'h00_04_04_3C_44_44_3C_00;
      8'h65: ink = 64'h00_00_38_44_7C_40_38_00;  8'h66: ink = 64'h00_18_20_78_20_20_20_00;
      8'h67: ink = 64'h00_00_3C_44_3C_04_38_00;  8'h68: ink = 64'h00_40_40_78_44_44_44_00;
      8'h69: ink = 64'h00_10_00_30_10_10_38_00;  8'h6A: ink = 64'h00_08_00_08_08_48_30_00;
      8'h6B: ink = 64'h00_40_48_50_60_50_48_00;  8'h6C: ink = 64'h00_30_10_10_10_10_38_00;
      8'h6D: ink = 64'h00_00_68_54_54_54_44_00;  8'h6E: ink = 64'h00_00_78_44_44_44_44_00;
      8'h6F: ink = 64'h00_00_38_44_44_44_38_00;  8'h70: ink = 64'h00_00_78_44_78_40_40_00;
      8'h71: ink = 64'h00_00_3C_44_3C_04_04_00;  8'h72: ink = 64'h00_00_58_64_40_40_40_00;
      8'h73: ink = 64'h00_00_3C_40_38_04_78_00;  8'h74: ink = 64'h00_20_78_20_20_24_18_00;
      8'h75: ink = 64'h00_00_44_44_44_4C_34_00;  8'h76: ink = 64'h00_00_44_44_44_28_10_00;
      8'h77: ink = 64'h00_00_44_44_54_54_28_00;  8'h78: ink = 64'h00_00_44_28_10_28_44_00;
      8'h79: ink = 64'h00_00_44_44_3C_04_38_00;  8'h7A: ink = 64'h00_00_7C_08_10_20_7C_00;
      8'h7B: ink = 64'h00_0C_10_20_10_10_0C_00;  8'h7C: ink = 64'h00_10_10_10_10_10_10_00;
      8'h7D: ink = 64'h00_60_10_08_10_10_60_00;  8'h7E: ink = 64'h00_00_34_58_00_00_00_00;
      default: ink = '0;
    endcase
    glyph = ~ink;
  end

endmodule

// File: rtl/chr_ascii_render.sv
// Renders one ASCII character as 64 raster-ordered pixels over a valid/ready stream.
// The glyph register shifts left per transfer so bit 63 is always the current pixel.
module chr_ascii_render
  import chr_ascii_render_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned GLYPH_ROWS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_enable,
  output logic                   in_ready,
  input  logic [7:0]             in_char,
  input  logic [COLOR_WIDTH-1:0] in_fg,
  input  logic [COLOR_WIDTH-1:0] in_bg,
  output logic                   out_enable,
  input  logic                   out_ready,
  output logic [COLOR_WIDTH-1:0] out_data,
  output logic [2:0]             out_x,
  output logic [2:0]             out_y,
  output logic                   out_last
);

  localparam logic [5:0] LAST_PIX = 6'(GLYPH_ROWS * CHR_W - 1);

  state_t                 state;
  logic [63:0]            glyph;
  logic [63:0]            rom_glyph;
  logic [5:0]             cnt;
  logic [COLOR_WIDTH-1:0] fg;
  logic [COLOR_WIDTH-1:0] bg;
  logic                   alive;
  logic [7:0]             code;
  logic                   accept;
  logic                   transfer;

  assign code = (in_char >= CHR_FIRST && in_char <= CHR_LAST) ? in_char : CHR_FIRST;

  chr_font_rom u_font (
    .index (code),
    .glyph (rom_glyph)
  );

  assign out_enable = (state == RUN);
  assign out_last   = out_enable && (cnt == LAST_PIX);
  assign out_x      = cnt[2:0];
  assign out_y      = cnt[5:3];
  assign out_data   = glyph[63] ? bg : fg;
  assign transfer   = out_enable && out_ready;
  // alive holds in_ready low during reset and until the first edge after release.
  assign in_ready   = out_enable ? (out_last && out_ready) : alive;
  assign accept     = in_enable && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      glyph <= '1;
      cnt   <= '0;
      fg    <= '0;
      bg    <= '0;
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
      // An accept in RUN only happens on the final transfer, so it takes priority.
      if (accept) begin
        glyph <= rom_glyph;
        fg    <= in_fg;
        bg    <= in_bg;
        cnt   <= '0;
        state <= RUN;
      end else if (transfer) begin
        glyph <= {glyph[62:0], 1'b1};
        cnt   <= cnt + 6'd1;
        if (out_last) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_chr_ascii_render.sv
// Directed bench for chr_ascii_render with an independent glyph/pixel model.
module tb_chr_ascii_render;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_enable = 1'b0;
  logic          in_ready;
  logic [7:0]    in_char = '0;
  logic [CW-1:0] in_fg = '0;
  logic [CW-1:0] in_bg = '0;
  logic          out_enable;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_data;
  logic [2:0]    out_x;
  logic [2:0]    out_y;
  logic          out_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chr_ascii_render #(.COLOR_WIDTH(CW), .GLYPH_ROWS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_enable  (in_enable),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_fg      (in_fg),
    .in_bg      (in_bg),
    .out_enable (out_enable),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last)
  );

  // Ink maps (1 = ink) for the characters exercised here; anything else is blank.
  function automatic logic [63:0] ink_of(input logic [7:0] c);
    case (c)
      8'h30:   return 64'h00_38_4C_54_64_44_38_00;
      8'h31:   return 64'h00_10_30_10_10_10_38_00;
      8'h41:   return 64'h00_18_24_42_7E_42_42_00;
      8'h42:   return 64'h00_78_44_78_44_44_78_00;
      8'h43:   return 64'h00_38_44_40_40_44_38_00;
      8'h57:   return 64'h00_44_44_44_54_6C_44_00;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [CW-1:0] pix_of(input logic [7:0] c, input int unsigned i,
                                           input logic [CW-1:0] fg, input logic [CW-1:0] bg);
    logic [63:0] ink;
    ink = ink_of(c);
    return ink[63-i] ? fg : bg;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({out_enable, out_last, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got en=%b last=%b rdy=%b, want 0 0 0", out_enable, out_last, in_ready);
    end
    checks++;
    if ({out_data, out_x, out_y} !== {8'h00, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_data: got d=%h x=%0d y=%0d, want 00 0 0", out_data, out_x, out_y);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, want 0 before first edge", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_single_a();
    in_char = 8'h41; in_fg = 8'hFF; in_bg = 8'h00; out_ready = 1'b1; in_enable = 1'b1;
    @(posedge clk); #1;
    in_enable = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      checks++;
      if ({out_enable, out_y, out_x, out_data, out_last} !==
          {1'b1, 3'(i / 8), 3'(i % 8), pix_of(8'h41, i, 8'hFF, 8'h00), (i == 63)}) begin
        errors++;
        $display("FAIL single_a pix=%0d: got en=%b y=%0d x=%0d d=%h last=%b, want d=%h last=%b",
                 i, out_enable, out_y, out_x, out_data, out_last, pix_of(8'h41, i, 8'hFF, 8'h00), (i == 63));
      end
      if (i == 12) begin
        checks++;
        if (out_data !== 8'hFF) begin
          errors++;
          $display("FAIL single_a_pix12: got %h, want ff", out_data);
        end
      end
      if (i < 8) begin
        checks++;
        if (out_data !== 8'h00) begin
          errors++;
          $display("FAIL single_a_row0 pix=%0d: got %h, want 00", i, out_data);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_enable, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_a_idle: got en=%b rdy=%b, want 0 1", out_enable, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]    c;
    logic [CW-1:0] f;
    logic [CW-1:0] b;
    in_char = 8'h30; in_fg = 8'h11; in_bg = 8'h22; out_ready = 1'b1; in_enable = 1'b1;
    @(posedge clk); #1;
    // Request stays up with new contents; it must wait for the final pixel.
    in_char = 8'h31; in_fg = 8'h33; in_bg = 8'h44;
    for (int unsigned i = 0; i < 128; i++) begin
      c = (i < 64) ? 8'h30 : 8'h31;
      f = (i < 64) ? 8'h11 : 8'h33;
      b = (i < 64) ? 8'h22 : 8'h44;
      if (i == 64) in_enable = 1'b0;
      checks++;
      if ({out_enable, out_y, out_x, out_data, out_last} !==
          {1'b1, 3'((i % 64) / 8), 3'(i % 8), pix_of(c, i % 64, f, b), ((i % 64) == 63)}) begin
        errors++;
        $display("FAIL back_to_back pix=%0d: got en=%b y=%0d x=%0d d=%h last=%b, want d=%h",
                 i, out_enable, out_y, out_x, out_data, out_last, pix_of(c, i % 64, f, b));
      end
      if (i < 64) begin
        checks++;
        if (in_ready !== (i == 63)) begin
          errors++;
          $display("FAIL busy_ready pix=%0d: got %b, want %b", i, in_ready, (i == 63));
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_enable !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_end: got en=%b, want 0", out_enable);
    end
  endtask

  task automatic test_invalid_code();
    in_char = 8'h05; in_fg = 8'hAA; in_bg = 8'h55; out_ready = 1'b1; in_enable = 1'b1;
    @(posedge clk); #1;
    in_enable = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      checks++;
      if ({out_enable, out_data} !== {1'b1, 8'h55}) begin
        errors++;
        $display("FAIL invalid_code pix=%0d: got en=%b d=%h, want 1 55", i, out_enable, out_data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int unsigned p = 0;
    int unsigned cyc = 0;
    logic [7:0]  lfsr = 8'hA5;
    logic        r;
    logic        stalled = 1'b0;
    logic [15:0] snap = '0;
    in_char = 8'h57; in_fg = 8'hC3; in_bg = 8'h3C; out_ready = 1'b1; in_enable = 1'b1;
    @(posedge clk); #1;
    in_enable = 1'b0;
    while (p < 64 && cyc < 600) begin
      checks++;
      if ({out_enable, out_y, out_x, out_data, out_last} !==
          {1'b1, 3'(p / 8), 3'(p % 8), pix_of(8'h57, p, 8'hC3, 8'h3C), (p == 63)}) begin
        errors++;
        $display("FAIL stall_seq pix=%0d: got en=%b y=%0d x=%0d d=%h last=%b, want d=%h",
                 p, out_enable, out_y, out_x, out_data, out_last, pix_of(8'h57, p, 8'hC3, 8'h3C));
      end
      if (stalled) begin
        checks++;
        if ({out_enable, out_y, out_x, out_data, out_last} !== snap) begin
          errors++;
          $display("FAIL stall_hold pix=%0d: got %h, want %h", p,
                   {out_enable, out_y, out_x, out_data, out_last}, snap);
        end
      end
      r = lfsr[0];
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      out_ready = r;
      snap = {out_enable, out_y, out_x, out_data, out_last};
      @(posedge clk); #1;
      if (r) p++;
      stalled = !r;
      cyc++;
    end
    checks++;
    if (p != 64) begin
      errors++;
      $display("FAIL stall_timeout: got %0d pixels, want 64", p);
    end
    out_ready = 1'b1;
    checks++;
    if (out_enable !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got en=%b, want 0", out_enable);
    end
  endtask

  task automatic test_reset_mid();
    in_char = 8'h42; in_fg = 8'h0F; in_bg = 8'hF0; out_ready = 1'b1; in_enable = 1'b1;
    @(posedge clk); #1;
    in_enable = 1'b0;
    for (int unsigned i = 0; i < 30; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({out_enable, out_y, out_x, out_data} !== {1'b1, 3'd3, 3'd6, pix_of(8'h42, 30, 8'h0F, 8'hF0)}) begin
      errors++;
      $display("FAIL reset_mid_pix30: got en=%b y=%0d x=%0d d=%h", out_enable, out_y, out_x, out_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_enable, out_last, in_ready, out_data} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_async: got en=%b last=%b rdy=%b d=%h, want 0 0 0 00",
               out_enable, out_last, in_ready, out_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_enable, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_after: got en=%b rdy=%b, want 0 1", out_enable, in_ready);
    end
    in_char = 8'h43; in_fg = 8'h77; in_bg = 8'h88; in_enable = 1'b1;
    @(posedge clk); #1;
    in_enable = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      checks++;
      if ({out_enable, out_y, out_x, out_data, out_last} !==
          {1'b1, 3'(i / 8), 3'(i % 8), pix_of(8'h43, i, 8'h77, 8'h88), (i == 63)}) begin
        errors++;
        $display("FAIL reset_mid_c pix=%0d: got en=%b y=%0d x=%0d d=%h last=%b, want d=%h",
                 i, out_enable, out_y, out_x, out_data, out_last, pix_of(8'h43, i, 8'h77, 8'h88));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_end: got en=%b, want 0", out_enable);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_back_to_back();
    test_invalid_code();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/chr_ascii_render.md
CHR_ASCII_RENDER -- requirements
Module: chr_ascii_render

Interface
REQ-001 Parameter COLOR_WIDTH, default 8, bit width of one output pixel.
REQ-002 Parameter GLYPH_ROWS, default 8, rows per glyph; fixed at 8 for this revision.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_enable  input  1  character request valid.
REQ-006 in_ready  output  1  block can accept a character this cycle.
REQ-007 in_char  input  8  ASCII code.
REQ-008 in_fg  input  COLOR_WIDTH  ink colour.
REQ-009 in_bg  input  COLOR_WIDTH  background colour.
REQ-010 out_enable  output  1  pixel valid.
REQ-011 out_ready  input  1  downstream accepts the pixel.
REQ-012 out_data  output  COLOR_WIDTH  pixel colour.
REQ-013 out_x  output  3  pixel column, 0 = left.
REQ-014 out_y  output  3  pixel row, 0 = top.
REQ-015 out_last  output  1  marks pixel (7,7).

Function
REQ-016 A character is accepted on any cycle with in_enable=1 and in_ready=1; in_char, in_fg and in_bg are latched on that cycle.
REQ-017 A code outside 0x20..0x7E is replaced by 0x20 (space) before glyph lookup.
REQ-018 Glyph lookup SHALL yield 64 bits; bit 63 is pixel (x=0, y=0); bit index = 63 - (8*y + x).
REQ-019 Glyph bit 0 -> out_data = latched fg; glyph bit 1 -> out_data = latched bg.
REQ-020 FSM has two states. IDLE: in_ready=1, out_enable=0. RUN: out_enable=1.
REQ-021 IDLE goes to RUN on acceptance; the first pixel (0,0) is presented on the cycle after acceptance (latency 1).
REQ-022 In RUN, each transfer (out_enable and out_ready) advances x; when x=7, x wraps to 0 and y increments.
REQ-023 out_last=1 exactly when x=7 and y=7 in RUN.
REQ-024 In RUN, in_ready = out_last and out_ready (back-to-back acceptance).
  - Accept on that cycle: the new glyph is loaded, state stays RUN, the next pixel is (0,0) of the new character, no bubble.
  - No accept: state goes to IDLE after the last transfer.
REQ-025 While out_ready=0, out_data, out_x, out_y, out_last and out_enable are held stable.
REQ-026 Exactly 64 pixels are emitted per accepted character, in raster order.

Reset
REQ-027 rst=1 SHALL immediately clear the following: state=IDLE, x=y=0, glyph register=all ones, colour registers=0, out_enable=0, out_last=0, out_data=0, in_ready=0.
REQ-028 After release, in_ready=1 from the first clock edge.
REQ-029 Reset mid-character abandons the character; no further pixels of it are emitted.

Structure
REQ-030 A shared package holds:
  - constants CHR_W=8, CHR_H=8, CHR_FIRST=8'h20, CHR_LAST=8'h7E;
  - the FSM state typedef.
REQ-031 The glyph table is one combinational sub-module, chr_font_rom (8-bit index in, 64-bit glyph out), instantiated once.
REQ-032 The block uses one 64-bit glyph shift or index register and one 6-bit pixel counter; x and y are the counter fields.

Verification
REQ-033 Single 'A' (0x41), fg=0xFF, bg=0x00, out_ready=1:
  - 64 pixels on consecutive cycles starting one cycle after accept;
  - pixel 12 (x=4, y=1) = 0xFF;
  - pixels 0..7 = 0x00;
  - out_last only on pixel 63.
REQ-034 Back-to-back '0' (0x30) then '1' (0x31), in_enable held high: 128 pixels with no gap; second accept coincides with the first out_last transfer.
REQ-035 Code 0x05 -> 64 pixels all = bg (rendered as space).
REQ-036 out_ready toggled with a pseudo-random pattern during 'W' (0x57): outputs are stable while stalled, and the pixel sequence equals the unstalled run.
REQ-037 rst asserted at pixel 30 of 'B' -> out_enable falls asynchronously; after release, 'C' renders from (0,0) correctly.
REQ-038 in_enable asserted while RUN and not at out_last -> no accept; in_ready=0; the request is taken on the final-pixel cycle.
